// File: rtl/gray_sync_nd.sv
// rtl/gray_sync_nd.sv - N-stage gray pointer synchroniser with binary decode, update strobe and integrity monitor
module gray_sync_nd #(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERRCNT_W    = 8
) (
    input  logic                des_clk,
    input  logic                des_rst_n,
    input  logic [ADDRSIZE:0]   i_ptr,
    input  logic                i_err_clr,
    output logic [ADDRSIZE:0]   o_ptr,
    output logic [ADDRSIZE:0]   o_bin,
    output logic                o_update,
    output logic                o_err,
    output logic [ERRCNT_W-1:0] o_err_cnt
);
    localparam int PW = ADDRSIZE + 1;
    localparam int CW = $clog2(PW + 1);
    localparam logic [ERRCNT_W-1:0] CNT_MAX = '1;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("gray_sync_nd: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    logic [PW-1:0]       r_sync [SYNC_STAGES];
    logic [PW-1:0]       r_prev;
    logic [PW-1:0]       r_bin;
    logic                r_update;
    logic                r_err;
    logic [ERRCNT_W-1:0] r_err_cnt;

    logic [PW-1:0]       w_diff;
    logic [CW-1:0]       w_popcnt;
    logic                w_err_evt;
    logic [PW-1:0]       w_bin;

    always_ff @(posedge des_clk or negedge des_rst_n) begin
        if (!des_rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= i_ptr;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // o_ptr leaves straight from the last flop so the consumer sees no glitching logic
    assign o_ptr = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_diff   = o_ptr ^ r_prev;
        w_popcnt = '0;
        for (int i = 0; i < PW; i++) begin
            w_popcnt = w_popcnt + CW'(w_diff[i]);
        end
        w_err_evt = (w_popcnt > CW'(1));
        w_bin     = '0;
        for (int i = 0; i < PW; i++) begin
            w_bin[i] = ^(o_ptr >> i);
        end
    end

    always_ff @(posedge des_clk or negedge des_rst_n) begin
        if (!des_rst_n) begin
            r_prev    <= '0;
            r_bin     <= '0;
            r_update  <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_prev   <= o_ptr;
            r_bin    <= w_bin;
            r_update <= (o_ptr != r_prev);
            // An event in the clear cycle wins: the counter restarts and then counts it
            if (w_err_evt) begin
                r_err <= 1'b1;
                if (i_err_clr) begin
                    r_err_cnt <= ERRCNT_W'(1);
                end else if (r_err_cnt != CNT_MAX) begin
                    r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
                end
            end else if (i_err_clr) begin
                r_err     <= 1'b0;
                r_err_cnt <= '0;
            end
        end
    end

    assign o_bin     = r_bin;
    assign o_update  = r_update;
    assign o_err     = r_err;
    assign o_err_cnt = r_err_cnt;
endmodule

// File: tb/tb_gray_sync_nd.sv
// tb/tb_gray_sync_nd.sv - randomized self-checking bench for gray_sync_nd (2- and 3-stage instances)
`timescale 1ns/1ps
module tb_gray_sync_nd;
    logic       des_clk = 1'b0;
    logic       des_rst_n = 1'b0;
    logic [4:0] i_ptr = '0;
    logic       i_err_clr = 1'b0;

    logic [4:0] o_ptr_2, o_bin_2, o_ptr_3, o_bin_3;
    logic       o_update_2, o_err_2, o_update_3, o_err_3;
    logic [7:0] o_err_cnt_2, o_err_cnt_3;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt2 = 0;

    always #5 des_clk = ~des_clk;

    gray_sync_nd #(.ADDRSIZE(4), .SYNC_STAGES(2), .ERRCNT_W(8)) u_dut2 (
        .des_clk(des_clk), .des_rst_n(des_rst_n), .i_ptr(i_ptr), .i_err_clr(i_err_clr),
        .o_ptr(o_ptr_2), .o_bin(o_bin_2), .o_update(o_update_2), .o_err(o_err_2), .o_err_cnt(o_err_cnt_2));

    gray_sync_nd #(.ADDRSIZE(4), .SYNC_STAGES(3), .ERRCNT_W(8)) u_dut3 (
        .des_clk(des_clk), .des_rst_n(des_rst_n), .i_ptr(i_ptr), .i_err_clr(i_err_clr),
        .o_ptr(o_ptr_3), .o_bin(o_bin_3), .o_update(o_update_3), .o_err(o_err_3), .o_err_cnt(o_err_cnt_3));

    // Reference: a delay line of input samples plus arithmetic on consecutive outputs
    logic [4:0] hist [4];
    logic [4:0] m_ptr [2];
    logic [4:0] m_prev [2];
    logic [4:0] m_bin [2];
    logic       m_upd [2];
    logic       m_err [2];
    int         m_cnt [2];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int popc(input logic [4:0] v);
        int c = 0;
        for (int i = 0; i < 5; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b = g;
        for (int s = 1; s < 5; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [4:0] b2g(input int b);
        logic [4:0] v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) hist[i] = '0;
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = '0; m_prev[d] = '0; m_bin[d] = '0;
            m_upd[d] = 1'b0; m_err[d] = 1'b0; m_cnt[d] = 0;
        end
    endtask

    task automatic model_edge();
        if (!des_rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            bit evt = popc(m_ptr[d] ^ m_prev[d]) > 1;
            m_bin[d] = g2b(m_ptr[d]);
            m_upd[d] = (m_ptr[d] != m_prev[d]);
            if (evt) begin
                m_err[d] = 1'b1;
                m_cnt[d] = i_err_clr ? 1 : ((m_cnt[d] + 1 > 255) ? 255 : m_cnt[d] + 1);
            end else if (i_err_clr) begin
                m_err[d] = 1'b0;
                m_cnt[d] = 0;
            end
            m_prev[d] = m_ptr[d];
        end
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = i_ptr;
        m_ptr[0] = hist[1];
        m_ptr[1] = hist[2];
    endtask

    task automatic cmp_all();
        chk("d2_ptr", int'(o_ptr_2), int'(m_ptr[0]));
        chk("d2_bin", int'(o_bin_2), int'(m_bin[0]));
        chk("d2_upd", int'(o_update_2), int'(m_upd[0]));
        chk("d2_err", int'(o_err_2), int'(m_err[0]));
        chk("d2_cnt", int'(o_err_cnt_2), m_cnt[0]);
        chk("d3_ptr", int'(o_ptr_3), int'(m_ptr[1]));
        chk("d3_bin", int'(o_bin_3), int'(m_bin[1]));
        chk("d3_upd", int'(o_update_3), int'(m_upd[1]));
        chk("d3_err", int'(o_err_3), int'(m_err[1]));
        chk("d3_cnt", int'(o_err_cnt_3), m_cnt[1]);
    endtask

    task automatic step();
        @(posedge des_clk);
        model_edge();
        @(negedge des_clk);
        cmp_all();
        if (o_update_2) upd_cnt2++;
    endtask

    task automatic hold(input logic [4:0] v, input int n);
        i_ptr = v;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ptr2"}, int'(o_ptr_2), 0);
        chk({tag, "_bin2"}, int'(o_bin_2), 0);
        chk({tag, "_upd2"}, int'(o_update_2), 0);
        chk({tag, "_err2"}, int'(o_err_2), 0);
        chk({tag, "_cnt2"}, int'(o_err_cnt_2), 0);
        chk({tag, "_ptr3"}, int'(o_ptr_3), 0);
        chk({tag, "_cnt3"}, int'(o_err_cnt_3), 0);
    endtask

    initial begin
        bit seen;
        int b;
        model_reset();

        // Reset held with a nonzero pointer, then release
        @(negedge des_clk);
        i_ptr = 5'b10101;
        #1 check_all_zero("rst_hold");
        for (int i = 0; i < 3; i++) step();
        des_rst_n = 1'b1;
        step(); step();
        chk("rst_ptr_e2", int'(o_ptr_2), 5'b10101);
        step();
        chk("rst_bin_e3", int'(o_bin_2), 5'b11001);
        chk("rst_upd_e3", int'(o_update_2), 1);
        chk("rst_err_e3", int'(o_err_2), 1);
        hold(5'b10101, 4);

        // Latency with 3 stages from a clean reset
        des_rst_n = 1'b0;
        hold(5'b00000, 2);
        des_rst_n = 1'b1;
        hold(5'b00000, 3);
        i_ptr = 5'b00001;
        step(); step(); step();
        chk("lat_ptr3_e3", int'(o_ptr_3), 1);
        step();
        chk("lat_bin3_e4", int'(o_bin_3), 1);
        chk("lat_upd3_e4", int'(o_update_3), 1);
        step();
        chk("lat_upd3_e5", int'(o_update_3), 0);
        chk("lat_err3", int'(o_err_3), 0);

        // Full gray count with wrap, starting from the wrap value
        hold(5'b00011, 4);
        hold(5'b00010, 4);
        hold(5'b00110, 4);
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        for (int k = 4; k < 32; k++) hold(b2g(k), 4);
        upd_cnt2 = 0;
        for (int k = 0; k < 32; k++) hold(b2g(k), 4);
        hold(b2g(0), 4);
        chk("gray_upd_pulses", upd_cnt2, 33);
        chk("gray_err", int'(o_err_2), 0);
        chk("gray_bin_end", int'(o_bin_2), 0);

        // Integrity errors and saturation
        hold(5'b00001, 4);
        hold(5'b00011, 4);
        hold(5'b00110, 4);
        chk("int_err", int'(o_err_2), 1);
        chk("int_cnt", int'(o_err_cnt_2), 1);
        for (int t = 0; t < 300; t++) hold((t % 2 == 0) ? 5'b00011 : 5'b00110, 4);
        chk("sat_cnt2", int'(o_err_cnt_2), 255);
        chk("sat_cnt3", int'(o_err_cnt_3), 255);

        // Clear without event, then clear coincident with a 3-bit jump
        hold(5'b00011, 6);
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        chk("clr_err", int'(o_err_2), 0);
        chk("clr_cnt", int'(o_err_cnt_2), 0);
        hold(5'b00011, 2);
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        i_ptr = 5'b01101;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (popc(m_ptr[0] ^ m_prev[0]) > 1) begin
                i_err_clr = 1'b1;
                step();
                i_err_clr = 1'b0;
                chk("clr_evt_err", int'(o_err_2), 1);
                chk("clr_evt_cnt", int'(o_err_cnt_2), 1);
                seen = 1;
            end else begin
                step();
            end
        end
        chk("clr_evt_seen", int'(seen), 1);
        hold(5'b01101, 4);

        // Build o_ptr=01100 with 5 errors, then reset asynchronously between edges
        hold(5'b01111, 4);
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        hold(5'b01100, 4); hold(5'b01111, 4); hold(5'b01100, 4);
        hold(5'b01111, 4); hold(5'b01100, 4);
        chk("mid_ptr", int'(o_ptr_2), 5'b01100);
        chk("mid_cnt", int'(o_err_cnt_2), 5);
        #2 des_rst_n = 1'b0;
        model_reset();
        #1 check_all_zero("async_rst");
        @(negedge des_clk);
        i_ptr = 5'b10101;
        step();
        des_rst_n = 1'b1;
        step(); step();
        chk("rerst_ptr", int'(o_ptr_2), 5'b10101);
        step();
        chk("rerst_bin", int'(o_bin_2), 5'b11001);
        chk("rerst_err", int'(o_err_2), 1);
        hold(5'b10101, 4);

        // Randomized pointer walk with occasional jumps and clears
        b = 0;
        for (int n = 0; n < 400; n++) begin
            int r = int'($urandom_range(0, 15));
            if (r == 0) b = b + int'($urandom_range(2, 9));
            else if (r < 12) b = b + 1;
            i_ptr = b2g(b % 32);
            i_err_clr = ($urandom_range(0, 15) == 0);
            step();
            i_err_clr = 1'b0;
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
